// File: rtl/tomasulo_regstat_file_if.sv
// Register-status file bus: issue rename port, CDB broadcast, flush,
// two read ports and the registered busy count.
//   master : issue stage / CDB side (drives requests, reads results)
//   slave  : the register-status file itself
interface tomasulo_regstat_file_if #(
  parameter int NREGS  = 8,
  parameter int DATA_W = 9,
  parameter int TAG_W  = 9,
  parameter int AW     = $clog2(NREGS)
);
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic [TAG_W-1:0]  issue_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              flush;
  logic [AW-1:0]     rs_addr;
  logic [AW-1:0]     rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [TAG_W-1:0]  rs_tag;
  logic [TAG_W-1:0]  rt_tag;
  logic [AW:0]       pending_cnt;

  modport master (
    output issue_valid, issue_rd, issue_tag,
    output cdb_valid, cdb_tag, cdb_data, flush,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, rs_tag, rt_tag, pending_cnt
  );

  modport slave (
    input  issue_valid, issue_rd, issue_tag,
    input  cdb_valid, cdb_tag, cdb_data, flush,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, rs_tag, rt_tag, pending_cnt
  );
endinterface

// File: rtl/tomasulo_regstat_file.sv
// Architectural register file with per-register producer label for a
// Tomasulo datapath. A label of all ones (NO_TAG) marks a valid value.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (entry i data = i, labels NO_TAG)
//   bus (slave) issue rename, CDB capture, flush, two combinational read
//               ports (rs/rt) and the registered busy count pending_cnt
// Optional feature: define REGSTAT_CDB_BYPASS_EN to forward a matching CDB
// broadcast onto the read ports in the same cycle.
module tomasulo_regstat_file #(
  parameter int NREGS  = 8,
  parameter int DATA_W = 9,
  parameter int TAG_W  = 9,
  parameter int AW     = $clog2(NREGS)
) (
  input logic                    clk,
  input logic                    rst_n,
  tomasulo_regstat_file_if.slave bus
);

  localparam logic [TAG_W-1:0] NO_TAG = {TAG_W{1'b1}};

  logic [DATA_W-1:0] data_q [NREGS];
  logic [TAG_W-1:0]  tag_q  [NREGS];
  logic [DATA_W-1:0] data_n [NREGS];
  logic [TAG_W-1:0]  tag_n  [NREGS];
  logic [AW:0]       pending_q;
  logic [AW:0]       pending_n;
  logic              cdb_hit;
  logic              issue_ok;

  // A NO_TAG broadcast would otherwise match every valid register.
  assign cdb_hit  = bus.cdb_valid && (bus.cdb_tag != NO_TAG);
  assign issue_ok = bus.issue_valid && (bus.issue_tag != NO_TAG) && !bus.flush;

  // Next state: CDB capture first, then the rename, so a same-cycle issue
  // to a capturing entry keeps the result but takes the newer label.
  always_comb begin
    pending_n = '0;
    for (int i = 0; i < NREGS; i++) begin
      data_n[i] = data_q[i];
      tag_n[i]  = tag_q[i];
      if (cdb_hit && (tag_q[i] == bus.cdb_tag)) begin
        data_n[i] = bus.cdb_data;
        tag_n[i]  = NO_TAG;
      end
      if (bus.flush) begin
        tag_n[i] = NO_TAG;
      end else if (issue_ok && (bus.issue_rd == AW'(i))) begin
        tag_n[i] = bus.issue_tag;
      end
      if (tag_n[i] != NO_TAG) begin
        pending_n = pending_n + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        data_q[i] <= DATA_W'(i);
        tag_q[i]  <= NO_TAG;
      end
      pending_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        data_q[i] <= data_n[i];
        tag_q[i]  <= tag_n[i];
      end
      pending_q <= pending_n;
    end
  end

  // Stored-state lookup; out-of-range addresses read as a valid zero.
  function automatic logic [DATA_W+TAG_W-1:0] rd_lookup(input logic [AW-1:0] addr);
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t;
    d = '0;
    t = NO_TAG;
    if (int'(addr) < NREGS) begin
      d = data_q[addr];
      t = tag_q[addr];
    end
    return {d, t};
  endfunction

  logic [DATA_W-1:0] rs_d, rt_d;
  logic [TAG_W-1:0]  rs_t, rt_t;

  always_comb begin
    {rs_d, rs_t} = rd_lookup(bus.rs_addr);
    {rt_d, rt_t} = rd_lookup(bus.rt_addr);
`ifdef REGSTAT_CDB_BYPASS_EN
    // Forward the broadcast to a reader still waiting on that producer.
    if (cdb_hit && (rs_t == bus.cdb_tag)) begin
      rs_d = bus.cdb_data;
      rs_t = NO_TAG;
    end
    if (cdb_hit && (rt_t == bus.cdb_tag)) begin
      rt_d = bus.cdb_data;
      rt_t = NO_TAG;
    end
`endif
  end

  assign bus.rs_data     = rs_d;
  assign bus.rs_tag      = rs_t;
  assign bus.rt_data     = rt_d;
  assign bus.rt_tag      = rt_t;
  assign bus.pending_cnt = pending_q;

endmodule

// File: doc/tomasulo_regstat_file.md
Name: tomasulo_regstat_file

Overview:
- Architectural register file with a per-register status label (producer tag), for the Tomasulo datapath.
- Generalises the fixed three-register data/label holders to NREGS entries, two read ports, one issue port and common-data-bus (CDB) capture.
- Sits between the issue stage, which reads operands and renames the destination, and the CDB, which returns results.
- Label value NO_TAG (all ones) means the register holds a valid value.

Parameters:
- NREGS, 8, number of architectural registers (≥2).
- DATA_W, 9, data width.
- TAG_W, 9, label width; NO_TAG = {TAG_W{1'b1}}.
- AW, $clog2(NREGS), register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  rename the destination this cycle.
- issue_rd  in  AW  destination register.
- issue_tag  in  TAG_W  producer tag; NO_TAG is illegal and the issue is ignored.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcasting producer tag.
- cdb_data  in  DATA_W  broadcast result.
- flush  in  1  synchronous: clear all labels (misspeculation recovery).
- rs_addr, rt_addr  in  AW  read addresses.
- rs_data, rt_data  out  DATA_W  read data.
- rs_tag, rt_tag  out  TAG_W  read label; NO_TAG means the data is valid.
- pending_cnt  out  AW+1  registered count of entries with label ≠ NO_TAG.

Behaviour:
- Reset (async, rst_n=0):
  - entry i data = i (zero-extended to DATA_W).
  - All labels = NO_TAG.
  - pending_cnt = 0.
- Reads: combinational from current state, zero latency, subject to the optional bypass below.
- Read of an out-of-range address (≥NREGS): data 0, tag NO_TAG.
- CDB capture, at posedge with cdb_valid=1 and cdb_tag ≠ NO_TAG:
  - Every entry whose label == cdb_tag loads cdb_data and its label becomes NO_TAG.
  - Multiple matches all update.
  - cdb_tag == NO_TAG is ignored, so valid registers are never overwritten.
- Issue, at posedge with issue_valid=1 and issue_rd < NREGS:
  - label[issue_rd] ← issue_tag.
  - Data is unchanged.
- Simultaneous issue and CDB hit on the same entry: data ← cdb_data and label ← issue_tag. The newer rename wins.
- Issue to an already-busy entry: the label is overwritten. A later CDB carrying the old tag does not update that entry.
- flush=1 at posedge:
  - All labels ← NO_TAG.
  - Data is kept, except that a CDB hit in the same cycle still writes data.
  - Issue in the same cycle is ignored.
  - pending_cnt ← 0.
- pending_cnt equals the popcount of busy labels after the edge's update. It is registered and visible the cycle after the change, and never exceeds NREGS.
- Reset asserted mid-operation restores the reset state immediately. Pending tags are lost.

Optional Feature:
- Macro: REGSTAT_CDB_BYPASS_EN.
- Defined: a read port whose addressed label == cdb_tag with cdb_valid=1 (cdb_tag ≠ NO_TAG) returns cdb_data and NO_TAG in the same cycle. An issue reading its sources while the producer broadcasts therefore sees the value.
- Not defined: reads return stored state only; the value appears the cycle after the broadcast.

Test Plan:
1. Reset, then read rs_addr=2, rt_addr=7 → rs_data=2, rt_data=7, both tags 9'h1FF, pending_cnt=0.
2. Issue rd=3, tag=9'h012, then read r3 → rs_tag=9'h012, rs_data=3, pending_cnt=1. Then CDB tag=9'h012, data=9'h0AB → next cycle r3 data 9'h0AB, tag NO_TAG, pending_cnt=0.
3. Issue r1 tag 9'h005 and r4 tag 9'h005, then CDB tag 9'h005, data 9'h055 → both r1 and r4 hold 9'h055 with NO_TAG.
4. r5 busy with 9'h020; same edge: CDB 9'h020 data 9'h111 plus issue r5 tag 9'h021 → r5 data 9'h111, tag 9'h021. Later CDB 9'h020 data 9'h1EE → r5 unchanged.
5. With the macro defined: r6 busy 9'h030, rs_addr=6, CDB 9'h030 data 9'h077 in the same cycle → rs_data=9'h077, rs_tag=NO_TAG combinationally. Without the macro → rs_tag=9'h030 that cycle, 9'h077 the next.
6. Three registers busy, then flush → next cycle all labels NO_TAG, data retained, pending_cnt=0. Also drop rst_n mid-sequence → immediate reset values.
